// File: rtl/fixed_point_sign_apply_pkg.sv
// Shared fixed-point helpers for the signed/magnitude conversion units.
// Holds the saturation limits as constant functions of the data width and the
// range classification used when re-applying a sign to a magnitude, so that
// this block and the absolute-value unit agree on which magnitudes fit.
package fixed_point_sign_apply_pkg;

  // Widest data path the helpers support; callers zero-extend into this.
  localparam int unsigned MaxWidth = 64;

  typedef logic [MaxWidth-1:0] wide_t;

  // Largest positive value, 2^(width-1)-1.
  function automatic wide_t fxp_maxp(input int unsigned width);
    return (wide_t'(1) << (width - 1)) - wide_t'(1);
  endfunction

  // Magnitude of the most negative value, 2^(width-1); as a width-bit
  // pattern this is also the two's-complement MIN (1000...0).
  function automatic wide_t fxp_min(input int unsigned width);
    return wide_t'(1) << (width - 1);
  endfunction

  // 1 when the magnitude cannot be represented with the requested sign.
  // Negative results reach one step further than positive ones.
  function automatic logic fxp_out_of_range(input wide_t mag, input logic neg,
                                            input int unsigned width);
    if (neg) begin
      return mag > fxp_min(width);
    end
    return mag > fxp_maxp(width);
  endfunction

endpackage

// File: rtl/fixed_point_pipe_slice.sv
// One pipeline register slice with valid/ready flow control.
// The slice loads when it is empty or when its current content leaves in the
// same cycle, so a full pipeline of slices sustains one beat per cycle.
// Ports:
//   CLK, RSTN    clock, asynchronous active-low reset
//   in_valid     upstream offers in_data
//   in_data      payload to capture
//   in_ready     slice can capture this cycle (combinational from out_ready)
//   out_valid    slice holds a beat
//   out_data     held payload, stable while out_valid && !out_ready
//   out_ready    downstream takes the held beat this cycle
module fixed_point_pipe_slice #(
  parameter int unsigned PayloadWidth = 10
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    in_valid,
  input  logic [PayloadWidth-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [PayloadWidth-1:0] out_data,
  input  logic                    out_ready
);

  logic                    valid_q, valid_d;
  logic [PayloadWidth-1:0] data_q, data_d;
  logic                    moves;
  logic                    loads;

  always_comb begin
    moves    = valid_q & out_ready;
    in_ready = ~valid_q | moves;
    loads    = in_valid & in_ready;
    valid_d  = loads | (valid_q & ~moves);
    data_d   = loads ? in_data : data_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/fixed_point_sign_apply.sv
// Re-applies a saved sign to an unsigned magnitude, producing a saturated
// two's-complement value. Two-stage valid/ready pipeline:
//   S1 classifies the range and registers the (conditionally inverted) operand,
//   S2 completes the negation with +1 or substitutes the saturation limit.
// Ports:
//   CLK, RSTN   clock, asynchronous active-low reset
//   VALUE_IN    unsigned magnitude
//   SIGN_IN     1 requests a negative result
//   VALID_IN    input beat valid
//   READY_OUT   input beat accepted this cycle (combinational from READY_IN)
//   VALUE_OUT   signed result (registered)
//   VALID_OUT   output beat valid (registered)
//   READY_IN    downstream accepts the output beat
//   OVERFLOW    current output beat was saturated (registered)
module fixed_point_sign_apply
  import fixed_point_sign_apply_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] VALUE_IN,
  input  logic             SIGN_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             VALID_OUT,
  input  logic             READY_IN,
  output logic             OVERFLOW
);

  localparam int unsigned      PayloadWidth = WIDTH + 2;
  localparam logic [WIDTH-1:0] MaxP         = WIDTH'(fxp_maxp(WIDTH));
  localparam logic [WIDTH-1:0] MinV         = WIDTH'(fxp_min(WIDTH));

  // Payload layout for both slices: {sign, ovf, value}.
  logic [PayloadWidth-1:0] s1_in_data, s1_data;
  logic [PayloadWidth-1:0] s2_in_data, s2_data;
  logic                    s1_valid, s2_valid;
  logic                    s2_in_ready;

  logic                    s1_in_ovf;
  logic [WIDTH-1:0]        s1_in_operand;
  logic                    s1_sign, s1_ovf;
  logic [WIDTH-1:0]        s1_operand;
  logic [WIDTH-1:0]        s2_in_value;
  logic                    unused_s2_sign;

  // Stage 1: classify and pre-invert so S2 only needs an incrementer.
  always_comb begin
    s1_in_ovf     = fxp_out_of_range(wide_t'(VALUE_IN), SIGN_IN, WIDTH);
    s1_in_operand = SIGN_IN ? ~VALUE_IN : VALUE_IN;
    s1_in_data    = {SIGN_IN, s1_in_ovf, s1_in_operand};
  end

  fixed_point_pipe_slice #(
    .PayloadWidth(PayloadWidth)
  ) u_s1 (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .in_valid (VALID_IN),
    .in_data  (s1_in_data),
    .in_ready (READY_OUT),
    .out_valid(s1_valid),
    .out_data (s1_data),
    .out_ready(s2_in_ready)
  );

  // Stage 2: finish negation or saturate. The increment's carry out is
  // dropped on purpose: -0 wraps to 0 and -2^(W-1) lands exactly on MIN.
  always_comb begin
    s1_sign    = s1_data[WIDTH+1];
    s1_ovf     = s1_data[WIDTH];
    s1_operand = s1_data[WIDTH-1:0];
    if (s1_ovf) begin
      s2_in_value = s1_sign ? MinV : MaxP;
    end else if (s1_sign) begin
      s2_in_value = s1_operand + WIDTH'(1);
    end else begin
      s2_in_value = s1_operand;
    end
    s2_in_data = {s1_sign, s1_ovf, s2_in_value};
  end

  fixed_point_pipe_slice #(
    .PayloadWidth(PayloadWidth)
  ) u_s2 (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .in_valid (s1_valid),
    .in_data  (s2_in_data),
    .in_ready (s2_in_ready),
    .out_valid(s2_valid),
    .out_data (s2_data),
    .out_ready(READY_IN)
  );

  assign VALID_OUT      = s2_valid;
  assign OVERFLOW       = s2_data[WIDTH];
  assign VALUE_OUT      = s2_data[WIDTH-1:0];
  // Sign travels with the beat for symmetry with S1 but is not needed here.
  assign unused_s2_sign = s2_data[WIDTH+1];

endmodule

// File: tb/tb_fixed_point_sign_apply.sv
module tb_fixed_point_sign_apply;

  localparam int unsigned W    = 8;
  localparam int          MaxP = (1 << (W - 1)) - 1;
  localparam int          MinV = -(1 << (W - 1));

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic [W-1:0] VALUE_IN;
  logic         SIGN_IN;
  logic         VALID_IN;
  logic         READY_OUT;
  logic [W-1:0] VALUE_OUT;
  logic         VALID_OUT;
  logic         READY_IN;
  logic         OVERFLOW;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] mag;
    logic         neg;
  } in_t;

  always #5 CLK = ~CLK;

  fixed_point_sign_apply #(
    .WIDTH(W)
  ) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .VALUE_IN (VALUE_IN),
    .SIGN_IN  (SIGN_IN),
    .VALID_IN (VALID_IN),
    .READY_OUT(READY_OUT),
    .VALUE_OUT(VALUE_OUT),
    .VALID_OUT(VALID_OUT),
    .READY_IN (READY_IN),
    .OVERFLOW (OVERFLOW)
  );

  // Reference: signed integer value of the request, clamped to the W-bit range.
  function automatic logic [W:0] ref_apply(input int mag, input bit neg);
    int v;
    bit ovf;
    v   = neg ? -mag : mag;
    ovf = 1'b0;
    if (v > MaxP) begin
      v   = MaxP;
      ovf = 1'b1;
    end else if (v < MinV) begin
      v   = MinV;
      ovf = 1'b1;
    end
    return {ovf, v[W-1:0]};
  endfunction

  task automatic drive(input logic vin, input logic [W-1:0] mag, input logic neg,
                       input logic rdy);
    VALID_IN = vin;
    VALUE_IN = mag;
    SIGN_IN  = neg;
    READY_IN = rdy;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (VALID_OUT !== 1'b0) begin
      errors++; $display("FAIL reset_valid_out: got %b expected 0", VALID_OUT);
    end
    checks++;
    if (VALUE_OUT !== '0) begin
      errors++; $display("FAIL reset_value_out: got %h expected 00", VALUE_OUT);
    end
    checks++;
    if (OVERFLOW !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", OVERFLOW);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    checks++;
    if (READY_OUT !== 1'b1) begin
      errors++; $display("FAIL reset_ready_out: got %b expected 1", READY_OUT);
    end
    @(negedge CLK);
  endtask

  // Three beats back to back; each must emerge exactly two cycles later.
  task automatic test_stream();
    logic [W-1:0] mags [3] = '{8'd5, 8'd5, 8'd0};
    logic         negs [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] exps [3] = '{8'h05, 8'hFB, 8'h00};
    int           acc_cyc [3];
    int           n_in = 0;
    int           n_out = 0;
    for (int c = 0; c < 8; c++) begin
      if (n_in < 3) drive(1'b1, mags[n_in], negs[n_in], 1'b1);
      else          drive(1'b0, '0, 1'b0, 1'b1);
      #1;
      if (VALID_OUT && READY_IN) begin
        checks++;
        if (n_out >= 3) begin
          errors++; $display("FAIL stream_extra_beat: got %h expected none", VALUE_OUT);
        end else begin
          if (VALUE_OUT !== exps[n_out]) begin
            errors++;
            $display("FAIL stream_value[%0d]: got %h expected %h", n_out, VALUE_OUT,
                     exps[n_out]);
          end
          checks++;
          if (OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL stream_ovf[%0d]: got %b expected 0", n_out, OVERFLOW);
          end
          checks++;
          if (c != acc_cyc[n_out] + 2) begin
            errors++;
            $display("FAIL stream_latency[%0d]: got %0d expected 2", n_out,
                     c - acc_cyc[n_out]);
          end
        end
        n_out++;
      end
      if (VALID_IN && READY_OUT) begin
        acc_cyc[n_in] = c;
        n_in++;
      end
      @(negedge CLK);
    end
    checks++;
    if (n_out != 3) begin
      errors++; $display("FAIL stream_count: got %0d expected 3", n_out);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] mags [5] = '{8'd127, 8'd128, 8'd128, 8'd200, 8'd255};
    logic         negs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] exps [5] = '{8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F};
    logic         ovfs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int           n_in = 0;
    int           n_out = 0;
    for (int c = 0; c < 10; c++) begin
      if (n_in < 5) drive(1'b1, mags[n_in], negs[n_in], 1'b1);
      else          drive(1'b0, '0, 1'b0, 1'b1);
      #1;
      if (VALID_OUT && READY_IN && n_out < 5) begin
        checks++;
        if (VALUE_OUT !== exps[n_out]) begin
          errors++;
          $display("FAIL boundary_value[%0d]: got %h expected %h", n_out, VALUE_OUT,
                   exps[n_out]);
        end
        checks++;
        if (OVERFLOW !== ovfs[n_out]) begin
          errors++;
          $display("FAIL boundary_ovf[%0d]: got %b expected %b", n_out, OVERFLOW,
                   ovfs[n_out]);
        end
        n_out++;
      end
      if (VALID_IN && READY_OUT) n_in++;
      @(negedge CLK);
    end
    checks++;
    if (n_out != 5) begin
      errors++; $display("FAIL boundary_count: got %0d expected 5", n_out);
    end
  endtask

  task automatic test_backpressure();
    in_t        beats [4];
    logic [W:0] exp;
    int         n_in = 0;
    int         n_out = 0;
    int         first_cyc = -1;
    beats[0] = '{mag: 8'd10,  neg: 1'b0};
    beats[1] = '{mag: 8'd20,  neg: 1'b1};
    beats[2] = '{mag: 8'd130, neg: 1'b0};
    beats[3] = '{mag: 8'd3,   neg: 1'b1};
    exp = ref_apply(int'(beats[0].mag), beats[0].neg);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, beats[n_in].mag, beats[n_in].neg, 1'b0);
      #1;
      if (VALID_OUT) begin
        checks++;
        if (VALUE_OUT !== exp[W-1:0]) begin
          errors++; $display("FAIL bp_hold_value: got %h expected %h", VALUE_OUT, exp[W-1:0]);
        end
      end
      if (VALID_IN && READY_OUT) n_in++;
      @(negedge CLK);
    end
    drive(1'b1, beats[n_in].mag, beats[n_in].neg, 1'b0);
    #1;
    checks++;
    if (n_in != 2) begin
      errors++; $display("FAIL bp_accepted: got %0d expected 2", n_in);
    end
    checks++;
    if (READY_OUT !== 1'b0) begin
      errors++; $display("FAIL bp_ready_out: got %b expected 0", READY_OUT);
    end
    checks++;
    if (VALID_OUT !== 1'b1 || VALUE_OUT !== exp[W-1:0]) begin
      errors++;
      $display("FAIL bp_head: got valid=%b value=%h expected valid=1 value=%h", VALID_OUT,
               VALUE_OUT, exp[W-1:0]);
    end
    @(negedge CLK);
    for (int c = 0; c < 12; c++) begin
      if (n_in < 4) drive(1'b1, beats[n_in].mag, beats[n_in].neg, 1'b1);
      else          drive(1'b0, '0, 1'b0, 1'b1);
      #1;
      if (c == 0) begin
        checks++;
        if (READY_OUT !== 1'b1) begin
          errors++; $display("FAIL bp_release_ready: got %b expected 1", READY_OUT);
        end
      end
      if (VALID_OUT && READY_IN && n_out < 4) begin
        exp = ref_apply(int'(beats[n_out].mag), beats[n_out].neg);
        if (first_cyc < 0) first_cyc = c;
        checks++;
        if (VALUE_OUT !== exp[W-1:0] || OVERFLOW !== exp[W]) begin
          errors++;
          $display("FAIL bp_drain[%0d]: got %b/%h expected %b/%h", n_out, OVERFLOW, VALUE_OUT,
                   exp[W], exp[W-1:0]);
        end
        checks++;
        if (c != first_cyc + n_out) begin
          errors++;
          $display("FAIL bp_gap[%0d]: got cycle %0d expected %0d", n_out, c,
                   first_cyc + n_out);
        end
        n_out++;
      end
      if (VALID_IN && READY_OUT) n_in++;
      @(negedge CLK);
    end
    checks++;
    if (n_out != 4) begin
      errors++; $display("FAIL bp_count: got %0d expected 4", n_out);
    end
  endtask

  task automatic test_random();
    in_t        q[$];
    in_t        head;
    in_t        b;
    logic [W:0] exp;
    int         accepted = 0;
    int         delivered = 0;
    for (int c = 0; c < 60000 && (accepted < 10000 || q.size() > 0); c++) begin
      b.mag = W'($urandom);
      b.neg = 1'($urandom);
      drive(accepted < 10000 && ($urandom_range(3) != 0), b.mag, b.neg,
            $urandom_range(3) != 0);
      #1;
      if (VALID_OUT) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: got %h expected no beat", VALUE_OUT);
        end else begin
          head = q[0];
          exp  = ref_apply(int'(head.mag), head.neg);
          if (VALUE_OUT !== exp[W-1:0] || OVERFLOW !== exp[W]) begin
            errors++;
            $display("FAIL rand_beat[%0d]: got %b/%h expected %b/%h (mag %0d neg %b)",
                     delivered, OVERFLOW, VALUE_OUT, exp[W], exp[W-1:0], head.mag, head.neg);
          end
          if (READY_IN) begin
            void'(q.pop_front());
            delivered++;
          end
        end
      end
      if (VALID_IN && READY_OUT) begin
        q.push_back(b);
        accepted++;
      end
      @(negedge CLK);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (accepted != 10000 || q.size() != 0 || delivered != 10000) begin
      errors++;
      $display("FAIL rand_complete: got accepted=%0d delivered=%0d pending=%0d expected 10000",
               accepted, delivered, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic [W:0] exp;
    int         n_out = 0;
    for (int c = 0; c < 6 && READY_OUT; c++) begin
      drive(1'b1, W'(40 + c), 1'b0, 1'b0);
      @(negedge CLK);
    end
    #1;
    checks++;
    if (VALID_OUT !== 1'b1 || READY_OUT !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_full: got valid=%b ready=%b expected 1/0", VALID_OUT, READY_OUT);
    end
    #1;
    RSTN = 1'b0;
    #1;
    checks++;
    if (VALID_OUT !== 1'b0 || VALUE_OUT !== '0 || OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got valid=%b value=%h ovf=%b expected 0/00/0", VALID_OUT,
               VALUE_OUT, OVERFLOW);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1);
    #1;
    checks++;
    if (READY_OUT !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b expected 1", READY_OUT);
    end
    @(negedge CLK);
    exp = ref_apply(77, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(1'b1, 8'd77, 1'b1, 1'b1);
      else        drive(1'b0, '0, 1'b0, 1'b1);
      #1;
      if (VALID_OUT) begin
        checks++;
        if (c != 2 || VALUE_OUT !== exp[W-1:0] || OVERFLOW !== exp[W]) begin
          errors++;
          $display("FAIL rst_mid_first: got cycle %0d value %h expected cycle 2 value %h", c,
                   VALUE_OUT, exp[W-1:0]);
        end
        n_out++;
      end
      @(negedge CLK);
    end
    checks++;
    if (n_out != 1) begin
      errors++; $display("FAIL rst_mid_count: got %0d expected 1", n_out);
    end
  endtask

  // Magnitude of the signed output must give back the original input.
  task automatic test_round_trip();
    in_t q[$];
    in_t head;
    int  n_in = 0;
    int  s;
    int  a;
    for (int c = 0; c < 700 && (n_in < 512 || q.size() > 0); c++) begin
      if (n_in < 512) drive(1'b1, W'(n_in % 256), 1'(n_in / 256), 1'b1);
      else            drive(1'b0, '0, 1'b0, 1'b1);
      #1;
      if (VALID_OUT && READY_IN && q.size() > 0) begin
        head = q.pop_front();
        s    = $signed(VALUE_OUT);
        a    = (s < 0) ? -s : s;
        checks++;
        if (ref_apply(int'(head.mag), head.neg) >> W) begin
          if (OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL rt_ovf: got %b expected 1 (mag %0d neg %b)", OVERFLOW, head.mag,
                     head.neg);
          end
        end else if (a != int'(head.mag) || OVERFLOW !== 1'b0) begin
          errors++;
          $display("FAIL rt_abs: got %0d ovf %b expected %0d ovf 0 (neg %b)", a, OVERFLOW,
                   head.mag, head.neg);
        end
      end
      if (VALID_IN && READY_OUT) begin
        q.push_back('{mag: VALUE_IN, neg: SIGN_IN});
        n_in++;
      end
      @(negedge CLK);
    end
    checks++;
    if (n_in != 512 || q.size() != 0) begin
      errors++;
      $display("FAIL rt_complete: got in=%0d pending=%0d expected 512/0", n_in, q.size());
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b1);
    test_reset();
    test_stream();
    test_boundaries();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_sign_apply.md
# fixed_point_sign_apply

Restores a signed two's-complement fixed-point value from a magnitude and a sign bit; it is the inverse companion of the absolute-value unit in the fixed-point datapath. It sits downstream of magnitude-domain processing such as scaling and comparison, and re-injects the saved sign before values return to the signed arithmetic chain. It is a two-stage pipeline with valid/ready flow control and saturation on out-of-range magnitudes.

## Interface
- WIDTH, 8, data width in bits; input magnitude and output value are both WIDTH bits; WIDTH ≥ 2
- CLK  input  1  clock; all logic on rising edge
- RSTN  input  1  reset; asynchronous, active-low
- VALUE_IN  input  WIDTH  unsigned magnitude, range 0 .. 2^WIDTH-1
- SIGN_IN  input  1  1 = negative result requested
- VALID_IN  input  1  input beat valid
- READY_OUT  output  1  block can accept an input beat this cycle
- VALUE_OUT  output  WIDTH  signed result, two's complement
- VALID_OUT  output  1  output beat valid
- READY_IN  input  1  downstream accepts the output beat
- OVERFLOW  output  1  qualifies the current output beat: magnitude did not fit and the result was saturated

## Operation
- Transfer happens on any edge where VALID and READY are both high, on each side independently.
- Stage 1 (S1) captures VALUE_IN and SIGN_IN and performs range classification. Let MAXP = 2^(WIDTH-1)-1.
  - Positive, magnitude ≤ MAXP: in range.
  - Negative, magnitude ≤ MAXP+1: in range.
  - Otherwise: overflow.
- S1 also registers the bitwise inverse of the magnitude when SIGN_IN = 1.
- Stage 2 (S2) adds 1 to the inverted operand for negative beats, and passes positive beats through unchanged.
  - Overflow beats saturate: positive → MAXP (0111…1), negative → MIN (1000…0). OVERFLOW = 1 for that beat only.
- Negative zero (magnitude 0, SIGN_IN = 1) outputs 0 with OVERFLOW = 0. The carry out of the increment is discarded.
- Negative magnitude 2^(WIDTH-1) outputs exactly MIN with OVERFLOW = 0. This is the exact inverse of the abs-unit corner case.
- Per-stage state is {valid, value, sign, ovf}, with no FSM beyond the per-stage valid bits.
- A stage loads when it is empty, or when its content moves forward in the same cycle.
  - S2 moves when READY_IN = 1.
  - S1 moves when S2 is empty or S2 moves.
- READY_OUT = !s1_valid || s1_moves. This is combinational from READY_IN, which is accepted on this short path.
- VALUE_OUT, VALID_OUT and OVERFLOW are registered and hold stable while VALID_OUT = 1 and READY_IN = 0.
- Beats are never dropped, duplicated or reordered.

## Timing
- Reset (RSTN low, asynchronous): s1_valid = s2_valid = 0; VALID_OUT = 0, OVERFLOW = 0, VALUE_OUT = 0. READY_OUT = 1 as soon as reset deasserts.
- Reset asserted mid-stream discards all in-flight beats immediately; no output beat is produced for them.
- Latency is 2 cycles: a beat accepted at edge N is presented with VALID_OUT = 1 after edge N+1 and can be consumed at edge N+2.
- Throughput is 1 beat/cycle while READY_IN = 1.
- Backpressure: with READY_IN = 0, the pipeline accepts at most 2 beats, then READY_OUT = 0.
- When READY_IN returns to 1 with both stages full, READY_OUT = 1 in the same cycle. On that edge:
  - S2 drains;
  - S1 shifts into S2;
  - a new beat loads S1.
- When VALID_IN is low, S1 empties and no bubble is inserted into S2 beyond the data actually present.

## Structure
- Shared fixed-point header/package holds:
  - MAXP/MIN constant functions of WIDTH;
  - the range-classification function, so it stays consistent with the abs unit.
- One natural sub-module: fixed_point_pipe_slice, a WIDTH+2-bit payload register with valid/ready and load/move logic, instantiated twice.
- Stage datapath logic (invert, increment, saturate mux) lives in the top level.

## Test plan
- WIDTH=8, stream {mag 5, s0}, {mag 5, s1}, {0, s1}, READY_IN = 1 → outputs 5, 0xFB, 0x00 on consecutive cycles, each 2 cycles after its input, OVERFLOW = 0.
- Boundaries: {127, s0} → 0x7F; {128, s1} → 0x80, OVERFLOW = 0; {128, s0} → 0x7F, OVERFLOW = 1; {200, s1} → 0x80, OVERFLOW = 1; {255, s0} → 0x7F, OVERFLOW = 1.
- Backpressure: hold READY_IN = 0 while feeding 4 beats → exactly 2 accepted, READY_OUT = 0 afterwards, VALUE_OUT stable. Release READY_IN → all 4 delivered in order with no gaps.
- Random VALID_IN/READY_IN toggling over 10k beats against a scoreboard model: no loss, no duplication, and results match saturated sign application.
- Assert RSTN mid-stream with both stages full → VALID_OUT drops without waiting for a clock edge. After release, READY_OUT = 1 and the first new beat appears after 2 cycles.
- Round-trip: feed this block's output through the abs unit and compare → original magnitude recovered for all non-overflow inputs.
